// File: rtl/dcache_ctrl_fsm.sv
// Write-back, write-allocate controller for a 2-way, 16-set data cache with 32-byte lines.
// Serves hits combinationally and sequences victim write-back plus line refill on a miss.
module dcache_ctrl_fsm (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_read_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic [3:0]   sram_index_o,
  output logic [24:0]  sram_tag_o,
  output logic [255:0] sram_data_o,
  output logic         sram_enable_o,
  output logic         sram_write_o,
  input  logic [24:0]  sram_tag_i,
  input  logic [255:0] sram_data_i,
  input  logic         sram_hit_i,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [15:0]  perf_hit_o,
  output logic [15:0]  perf_miss_o
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StMiss      = 3'd1;
  localparam logic [2:0] StWriteback = 3'd2;
  localparam logic [2:0] StRefill    = 3'd3;
  localparam logic [2:0] StRefillDone = 3'd4;

  logic [2:0]   r_state;
  logic [2:0]   w_state_d;
  logic [22:0]  r_tag;
  logic [3:0]   r_index;
  logic [24:0]  r_vic_tag;
  // Holds the victim line until write-back completes, then the refilled line.
  logic [255:0] r_line;
  logic [15:0]  r_hit_cnt;
  logic [15:0]  r_miss_cnt;

  logic         w_req;
  logic [2:0]   w_word;
  logic [255:0] w_merged;
  logic         w_unused_addr;

  assign w_req         = (cpu_read_i | cpu_write_i) & ~rst_i;
  assign w_word        = cpu_addr_i[4:2];
  assign w_unused_addr = ^cpu_addr_i[1:0];
  assign perf_hit_o    = r_hit_cnt;
  assign perf_miss_o   = r_miss_cnt;

  always_comb begin
    w_merged = sram_data_i;
    w_merged[{w_word, 5'b00000} +: 32] = cpu_data_i;
  end

  always_comb begin
    w_state_d     = r_state;
    cpu_data_o    = 32'h0;
    cpu_stall_o   = 1'b0;
    sram_index_o  = r_index;
    sram_tag_o    = {2'b11, r_tag};
    sram_data_o   = 256'h0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = 32'h0;
    mem_data_o    = 256'h0;
    case (r_state)
      StIdle: begin
        sram_index_o = cpu_addr_i[8:5];
        sram_tag_o   = {2'b11, cpu_addr_i[31:9]};
        cpu_data_o   = sram_data_i[{w_word, 5'b00000} +: 32];
        if (w_req) begin
          if (sram_hit_i) begin
            if (cpu_write_i) begin
              sram_enable_o = 1'b1;
              sram_write_o  = 1'b1;
              sram_data_o   = w_merged;
            end
          end else begin
            cpu_stall_o = 1'b1;
            w_state_d   = StMiss;
          end
        end
      end
      StMiss: begin
        cpu_stall_o = 1'b1;
        w_state_d   = (r_vic_tag[24] & r_vic_tag[23]) ? StWriteback : StRefill;
      end
      StWriteback: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {r_vic_tag[22:0], r_index, 5'b00000};
        mem_data_o   = r_line;
        if (mem_ack_i) w_state_d = StRefill;
      end
      StRefill: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {r_tag, r_index, 5'b00000};
        if (mem_ack_i) w_state_d = StRefillDone;
      end
      StRefillDone: begin
        cpu_stall_o   = 1'b1;
        sram_enable_o = 1'b1;
        sram_write_o  = 1'b1;
        sram_tag_o    = {2'b10, r_tag};
        sram_data_o   = r_line;
        w_state_d     = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    // Reset forces every output quiet, even with a CPU request held.
    if (rst_i) begin
      cpu_data_o    = 32'h0;
      cpu_stall_o   = 1'b0;
      sram_index_o  = 4'h0;
      sram_tag_o    = 25'h0;
      sram_data_o   = 256'h0;
      sram_enable_o = 1'b0;
      sram_write_o  = 1'b0;
      mem_enable_o  = 1'b0;
      mem_write_o   = 1'b0;
      mem_addr_o    = 32'h0;
      mem_data_o    = 256'h0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_tag      <= 23'h0;
      r_index    <= 4'h0;
      r_vic_tag  <= 25'h0;
      r_line     <= 256'h0;
      r_hit_cnt  <= 16'h0;
      r_miss_cnt <= 16'h0;
    end else begin
      r_state <= w_state_d;
      if ((r_state == StIdle) && w_req) begin
        if (sram_hit_i) begin
          r_hit_cnt <= r_hit_cnt + 16'h1;
        end else begin
          r_tag      <= cpu_addr_i[31:9];
          r_index    <= cpu_addr_i[8:5];
          r_vic_tag  <= sram_tag_i;
          r_line     <= sram_data_i;
          r_miss_cnt <= r_miss_cnt + 16'h1;
        end
      end
      if ((r_state == StRefill) && mem_ack_i) r_line <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// Bench for dcache_ctrl_fsm: behavioural 2-way LRU SRAM and fixed-latency memory around the DUT.
module tb_dcache_ctrl_fsm;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_read_i, cpu_write_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o;
  logic [3:0]   sram_index_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i;
  logic         sram_enable_o, sram_write_o, sram_hit_i;
  logic         mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic [15:0]  perf_hit_o, perf_miss_o;

  always #5 clk_i = ~clk_i;

  dcache_ctrl_fsm dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_read_i(cpu_read_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_index_o(sram_index_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o), .sram_tag_i(sram_tag_i),
    .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .perf_hit_o(perf_hit_o), .perf_miss_o(perf_miss_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory: fixed line pattern, except word2 of line 0x40 which is 0xDEADBEEF.
  function automatic logic [255:0] mline(input logic [31:0] a);
    logic [255:0] l;
    logic [2:0]   wv;
    for (int w = 0; w < 8; w++) begin
      wv = w[2:0];
      l[32*w +: 32] = (a == 32'h40 && w == 2) ? 32'hDEADBEEF : {a[15:0], 8'hA5, 5'b0, wv};
    end
    return l;
  endfunction

  int mem_lat;
  int mem_cnt;
  assign mem_ack_i  = mem_enable_o && (mem_cnt == mem_lat - 1);
  assign mem_data_i = mline(mem_addr_o);

  always @(posedge clk_i) begin
    if (!mem_enable_o || mem_ack_i) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
  end

  logic         ev_wr   [8];
  logic [31:0]  ev_addr [8];
  logic [255:0] ev_data [8];
  int           ev_n = 0;
  int           sram_wr_cnt = 0;

  always @(posedge clk_i) begin
    if (mem_ack_i && ev_n < 8) begin
      ev_wr[ev_n]   <= mem_write_o;
      ev_addr[ev_n] <= mem_addr_o;
      ev_data[ev_n] <= mem_data_o;
      ev_n          <= ev_n + 1;
    end
  end

  // SRAM model: tag word {valid, dirty, tag}, one LRU bit per set.
  logic [24:0]  m_tag  [2][16];
  logic [255:0] m_data [2][16];
  logic         m_lru  [16];
  logic         hit0, hit1, hway, vway;

  always_comb begin
    hit0 = m_tag[0][sram_index_o][24] && (m_tag[0][sram_index_o][22:0] == sram_tag_o[22:0]);
    hit1 = m_tag[1][sram_index_o][24] && (m_tag[1][sram_index_o][22:0] == sram_tag_o[22:0]);
    hway = hit1;
    sram_hit_i  = hit0 | hit1;
    vway        = sram_hit_i ? hway : m_lru[sram_index_o];
    sram_tag_i  = m_tag[vway][sram_index_o];
    sram_data_i = m_data[vway][sram_index_o];
  end

  always @(posedge clk_i) begin
    if (sram_enable_o && sram_write_o) begin
      m_tag[vway][sram_index_o]  <= sram_tag_o;
      m_data[vway][sram_index_o] <= sram_data_o;
      m_lru[sram_index_o]        <= ~vway;
      sram_wr_cnt                <= sram_wr_cnt + 1;
    end else if ((cpu_read_i || cpu_write_i) && sram_hit_i && !cpu_stall_o && !rst_i) begin
      m_lru[sram_index_o] <= ~hway;
    end
  end

  logic [31:0]  c_data;
  logic         c_swr;
  logic [24:0]  c_stag;
  logic [255:0] c_sdata;
  int           e_hits = 0;
  int           stalls;

  // Holds the request until the stall-free hit cycle, capturing outputs there.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int st);
    bit done = 0;
    cpu_read_i = r; cpu_write_i = w; cpu_addr_i = a; cpu_data_i = d;
    st = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk_i);
      if (cpu_stall_o) begin
        st++;
        @(posedge clk_i); #1;
      end else begin
        c_data = cpu_data_o; c_swr = sram_enable_o & sram_write_o;
        c_stag = sram_tag_o; c_sdata = sram_data_o;
        done = 1;
      end
    end
    if (!done) begin
      n_chk++; n_err++;
      $display("FAIL access_timeout: addr %h still stalled after 400 cycles", a);
    end else begin
      e_hits++;
    end
    @(posedge clk_i); #1;
    cpu_read_i = 0; cpu_write_i = 0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        chk_data;
    logic        exp_swr;
  } vec_t;

  vec_t vecs [8];
  int   n0, w0;
  bit   found;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h044, 32'h0,        32'h12345678, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h048, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h04C, 32'hA1A1A1A1, 32'h0040A503, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'h04C, 32'h0,        32'hA1A1A1A1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h85C, 32'h0,        32'h0840A507, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h840, 32'h5555AAAA, 32'h0840A500, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'h840, 32'h0,        32'h5555AAAA, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h840, 32'h0,        32'h0,        1'b0, 1'b0};

    for (int s = 0; s < 16; s++) begin
      m_tag[0][s] = '0; m_tag[1][s] = '0; m_data[0][s] = '0; m_data[1][s] = '0; m_lru[s] = 0;
    end
    rst_i = 1; cpu_read_i = 0; cpu_write_i = 0; cpu_addr_i = 0; cpu_data_i = 0;
    mem_lat = 10;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_stall", {31'b0, cpu_stall_o}, 32'h0);
    chk("rst_mem_en", {31'b0, mem_enable_o}, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_perf", {perf_hit_o, perf_miss_o}, 32'h0);
    rst_i = 0;
    @(posedge clk_i); #1;

    // Cold miss, L=10.
    access(1, 0, 32'h48, 32'h0, stalls);
    chk("cold_stall", stalls, 32'd13);
    chk("cold_data", c_data, 32'hDEADBEEF);
    chk("cold_mem_wr", {31'b0, ev_wr[0]}, 32'h0);
    chk("cold_mem_addr", ev_addr[0], 32'h40);
    chk("cold_perf_miss", {16'h0, perf_miss_o}, 32'd1);
    chk("cold_perf_hit", {16'h0, perf_hit_o}, 32'd1);

    access(0, 1, 32'h44, 32'h12345678, stalls);
    chk("st_stall", stalls, 32'd0);
    chk("st_swr", {31'b0, c_swr}, 32'h1);
    chk("st_tag", {7'b0, c_stag}, 32'h0180_0000);
    chk("st_word1", c_sdata[63:32], 32'h12345678);
    chk("st_word2_kept", c_sdata[95:64], 32'hDEADBEEF);

    access(0, 1, 32'h440, 32'hCAFE0440, stalls);
    chk("fill2_stall", stalls, 32'd13);
    access(1, 0, 32'h40, 32'h0, stalls);
    chk("touch_stall", stalls, 32'd0);
    chk("touch_data", c_data, 32'h0040A500);

    // Dirty victim 0x440 must be written back before refilling 0x840, L=3.
    mem_lat = 3;
    n0 = ev_n;
    access(1, 0, 32'h840, 32'h0, stalls);
    chk("dirty_stall", stalls, 32'd9);
    chk("dirty_ev_count", ev_n, n0 + 2);
    chk("wb_is_write", {31'b0, ev_wr[n0]}, 32'h1);
    chk("wb_addr", ev_addr[n0], 32'h440);
    chk("wb_data", ev_data[n0][31:0], 32'hCAFE0440);
    chk("rf_is_read", {31'b0, ev_wr[n0+1]}, 32'h0);
    chk("rf_addr", ev_addr[n0+1], 32'h840);
    chk("dirty_data", c_data, 32'h0840A500);

    n0 = ev_n;
    access(1, 0, 32'h840, 32'h0, stalls);
    chk("rehit_stall", stalls, 32'd0);
    chk("rehit_no_mem", ev_n, n0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rd || vecs[i].wr) begin
        access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, stalls);
        chk($sformatf("vec%0d_stall", i), stalls, 32'd0);
        chk($sformatf("vec%0d_swr", i), {31'b0, c_swr}, {31'b0, vecs[i].exp_swr});
        if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), c_data, vecs[i].exp_data);
      end else begin
        cpu_read_i = 0; cpu_write_i = 0; cpu_addr_i = vecs[i].addr;
        @(negedge clk_i);
        chk($sformatf("vec%0d_idle_stall", i), {31'b0, cpu_stall_o}, 32'h0);
        chk($sformatf("vec%0d_idle_swr", i), {31'b0, sram_write_o}, 32'h0);
        @(posedge clk_i); #1;
      end
    end
    chk("perf_hit_sum", {16'h0, perf_hit_o}, e_hits);
    chk("perf_miss_sum", {16'h0, perf_miss_o}, 32'd3);

    // Reset while in REFILL: request abandoned, no SRAM write, next access misses again.
    mem_lat = 10;
    cpu_read_i = 1; cpu_addr_i = 32'h1060;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk_i);
      if (mem_enable_o && !mem_write_o) found = 1;
    end
    chk("reach_refill", {31'b0, found}, 32'h1);
    w0 = sram_wr_cnt;
    @(negedge clk_i);
    rst_i = 1;
    #1;
    chk("rst_mid_mem_en", {31'b0, mem_enable_o}, 32'h0);
    chk("rst_mid_stall", {31'b0, cpu_stall_o}, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    cpu_read_i = 0;
    rst_i = 0;
    @(posedge clk_i); #1;
    chk("rst_mid_no_sram_wr", sram_wr_cnt, w0);
    chk("rst_mid_perf", {perf_hit_o, perf_miss_o}, 32'h0);
    e_hits = 0;
    access(1, 0, 32'h1060, 32'h0, stalls);
    chk("after_rst_miss_stall", stalls, 32'd13);
    chk("after_rst_perf_miss", {16'h0, perf_miss_o}, 32'd1);

    while (e_hits < 65535) access(1, 0, 32'h1060, 32'h0, stalls);
    chk("perf_hit_max", {16'h0, perf_hit_o}, 32'h0000FFFF);
    access(1, 0, 32'h1060, 32'h0, stalls);
    chk("perf_hit_wrap", {16'h0, perf_hit_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
